// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   Pipeline MEM stage. It takes the EXE->MEM register outputs, performs loads
//   and stores against a single-port data memory over a req/ack handshake,
//   and registers the write-back result for WB. While an access is
//   outstanding it holds EXE through STALL_fMEM. The registered WB result is
//   also driven back to EXE as the MEM->EXE bypass.
//
// Ports
//   CLK, RESET                      clock (posedge), async active-high reset
//   Instr1_IN / Instr1_PC_IN        debug instruction / PC from EXE
//   ALU_result1_IN                  ALU result or effective address
//   WriteRegister1_IN               destination register
//   MemWriteData1_IN                store data
//   RegWrite1_IN, MemRead1_IN,
//   MemWrite1_IN                    control
//   ALU_Control1_IN                 load/store width and sign code
//   STALL_fMEM                      EXE must hold its outputs
//   dmem_req/we/addr/be/wdata       memory request side (be[3] = byte 0)
//   dmem_ack/rdata                  memory response side
//   Instr1_OUT .. RegWrite1_OUT     registered result to WB
//   Bypass*_MEMEXE                  copy of the registered WB result
//   align_err                       sticky misaligned-access flag
//   stall_cycles                    count of stalled cycles (wraps)
// ---------------------------------------------------------------------------
module mem_stage (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr1_IN,
    input  logic [31:0] Instr1_PC_IN,
    input  logic [31:0] ALU_result1_IN,
    input  logic [4:0]  WriteRegister1_IN,
    input  logic [31:0] MemWriteData1_IN,
    input  logic        RegWrite1_IN,
    input  logic        MemRead1_IN,
    input  logic        MemWrite1_IN,
    input  logic [5:0]  ALU_Control1_IN,
    output logic        STALL_fMEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr1_PC_OUT,
    output logic [4:0]  WriteRegister1_OUT,
    output logic [31:0] WriteData1_OUT,
    output logic        RegWrite1_OUT,
    output logic [4:0]  BypassReg1_MEMEXE,
    output logic [31:0] BypassData1_MEMEXE,
    output logic        BypassValid1_MEMEXE,
    output logic        align_err,
    output logic [31:0] stall_cycles
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t state, state_nxt;

    // ---------------- access decode ----------------
    logic is_byte, is_half, is_word, is_signed;
    logic memop, misalign, aligned_memop;

    always_comb begin
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        is_signed = 1'b0;
        case (ALU_Control1_IN)
            OP_LB:         begin is_byte = 1'b1; is_signed = 1'b1; end
            OP_LBU, OP_SB: is_byte = 1'b1;
            OP_LH:         begin is_half = 1'b1; is_signed = 1'b1; end
            OP_LHU, OP_SH: is_half = 1'b1;
            OP_LW, OP_SW:  is_word = 1'b1;
            default:       ;
        endcase
    end

    assign memop         = MemRead1_IN | MemWrite1_IN;
    assign misalign      = memop & ((is_half & ALU_result1_IN[0]) |
                                    (is_word & (ALU_result1_IN[1:0] != 2'b00)));
    assign aligned_memop = memop & ~misalign;

    // ---------------- request formation (from live inputs) ----------------
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    always_comb begin
        be_c    = 4'b0000;
        wdata_c = MemWriteData1_IN;
        if (is_byte) begin
            wdata_c = {4{MemWriteData1_IN[7:0]}};
        end else if (is_half) begin
            wdata_c = {2{MemWriteData1_IN[15:0]}};
        end
        if (MemWrite1_IN) begin
            if (is_byte)
                be_c = 4'b1000 >> ALU_result1_IN[1:0];
            else if (is_half)
                be_c = ALU_result1_IN[1] ? 4'b0011 : 4'b1100;
            else
                be_c = 4'b1111;
        end
    end

    // Request fields captured on entry to WAIT so the bus stays frozen even
    // if the upstream hold were ever imperfect.
    logic        hold_we;
    logic [31:0] hold_addr;
    logic [3:0]  hold_be;
    logic [31:0] hold_wdata;

    // Reset gates the combinational request so an access in flight is
    // dropped the moment RESET rises, not at the next edge.
    assign dmem_req   = ~RESET & ((state == S_WAIT) | aligned_memop);
    assign STALL_fMEM = dmem_req & ~dmem_ack;

    always_comb begin
        dmem_we    = 1'b0;
        dmem_addr  = 32'h0;
        dmem_be    = 4'b0000;
        dmem_wdata = 32'h0;
        if (dmem_req) begin
            if (state == S_WAIT) begin
                dmem_we    = hold_we;
                dmem_addr  = hold_addr;
                dmem_be    = hold_be;
                dmem_wdata = hold_wdata;
            end else begin
                dmem_we    = MemWrite1_IN;
                dmem_addr  = {ALU_result1_IN[31:2], 2'b00};
                dmem_be    = be_c;
                dmem_wdata = wdata_c;
            end
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (aligned_memop && !dmem_ack) state_nxt = S_WAIT;
            S_WAIT:  if (dmem_ack)                   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= S_IDLE;
            hold_we    <= 1'b0;
            hold_addr  <= 32'h0;
            hold_be    <= 4'b0000;
            hold_wdata <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && state_nxt == S_WAIT) begin
                hold_we    <= MemWrite1_IN;
                hold_addr  <= {ALU_result1_IN[31:2], 2'b00};
                hold_be    <= be_c;
                hold_wdata <= wdata_c;
            end
        end
    end

    // ---------------- load alignment (big-endian lanes) ----------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    always_comb begin
        case (ALU_result1_IN[1:0])
            2'd0:    ld_byte = dmem_rdata[31:24];
            2'd1:    ld_byte = dmem_rdata[23:16];
            2'd2:    ld_byte = dmem_rdata[15:8];
            default: ld_byte = dmem_rdata[7:0];
        endcase
        ld_half   = ALU_result1_IN[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
        load_data = dmem_rdata;
        if (is_byte)
            load_data = {{24{is_signed & ld_byte[7]}}, ld_byte};
        else if (is_half)
            load_data = {{16{is_signed & ld_half[15]}}, ld_half};
    end

    // ---------------- MEM/WB register ----------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Instr1_OUT         <= 32'h0;
            Instr1_PC_OUT      <= 32'h0;
            WriteRegister1_OUT <= 5'd0;
            WriteData1_OUT     <= 32'h0;
            RegWrite1_OUT      <= 1'b0;
        end else if (STALL_fMEM) begin
            // Stalled edge: full bubble so WB and the bypass see nothing.
            Instr1_OUT         <= 32'h0;
            Instr1_PC_OUT      <= 32'h0;
            WriteRegister1_OUT <= 5'd0;
            WriteData1_OUT     <= 32'h0;
            RegWrite1_OUT      <= 1'b0;
        end else if (misalign) begin
            // Dropped access: keep debug trace, suppress the write-back.
            Instr1_OUT         <= Instr1_IN;
            Instr1_PC_OUT      <= Instr1_PC_IN;
            WriteRegister1_OUT <= WriteRegister1_IN;
            WriteData1_OUT     <= ALU_result1_IN;
            RegWrite1_OUT      <= 1'b0;
        end else begin
            Instr1_OUT         <= Instr1_IN;
            Instr1_PC_OUT      <= Instr1_PC_IN;
            WriteRegister1_OUT <= WriteRegister1_IN;
            WriteData1_OUT     <= MemRead1_IN ? load_data : ALU_result1_IN;
            RegWrite1_OUT      <= RegWrite1_IN;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            align_err    <= 1'b0;
            stall_cycles <= 32'h0;
        end else begin
            if (misalign)
                align_err <= 1'b1;
            if (STALL_fMEM)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

    assign BypassReg1_MEMEXE   = WriteRegister1_OUT;
    assign BypassData1_MEMEXE  = WriteData1_OUT;
    assign BypassValid1_MEMEXE = RegWrite1_OUT;

endmodule
